mcif_axi_wr_responder: RTL and testbench

- AXI write-channel responder (slave end) for the MCIF write ingress AW/W output interface.
- Accepts AW commands and W beats, and converts each beat into a write on a simple SRAM-style port.
- Returns one B response per burst.
- Used as the NOC-side memory model in MCIF subsystem benches and as a front end for on-chip scratch memory.

---
 rtl/mcif_axi_wr_pkg.sv | 20 ++
 rtl/mcif_axi_sync_fifo.sv | 51 +++++
 rtl/mcif_axi_wr_responder.sv | 196 +++++++++++++++++++
 tb/tb_mcif_axi_wr_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_axi_wr_pkg.sv
// Shared constants and types for the MCIF AXI write responder.
// Response codes, FSM state encoding and beat sizing helper.
package mcif_axi_wr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 64;
  localparam int BEAT_BYTES = DEF_DATA_W / 8;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mcif_axi_sync_fifo.sv
// Generic synchronous FIFO, head visible the cycle after push; DEPTH must be a power of 2.
// No internal backpressure: callers must not push when full or pop when empty.
module mcif_axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;

endmodule

// File: rtl/mcif_axi_wr_responder.sv
// AXI write slave: AW/W bursts become SRAM-port writes, one B per burst in AW order.
// Data cycles start 2 cycles after AW, B the cycle after the last beat; W stalls on mem_wr_ready or a full B FIFO.
module mcif_axi_wr_responder
  import mcif_axi_wr_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 8,
  parameter int AW_DEPTH = 4,
  parameter int B_DEPTH  = 4
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  mcif2noc_axi_aw_awvalid,
  output logic                  mcif2noc_axi_aw_awready,
  input  logic [ID_W-1:0]       mcif2noc_axi_aw_awid,
  input  logic [3:0]            mcif2noc_axi_aw_awlen,
  input  logic [ADDR_W-1:0]     mcif2noc_axi_aw_awaddr,
  input  logic                  mcif2noc_axi_w_wvalid,
  output logic                  mcif2noc_axi_w_wready,
  input  logic [DATA_W-1:0]     mcif2noc_axi_w_wdata,
  input  logic [63:0]           mcif2noc_axi_w_wstrb,
  input  logic                  mcif2noc_axi_w_wlast,
  output logic                  noc2mcif_axi_b_bvalid,
  input  logic                  noc2mcif_axi_b_bready,
  output logic [ID_W-1:0]       noc2mcif_axi_b_bid,
  output logic [1:0]            noc2mcif_axi_b_bresp,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [DATA_W-1:0]     mem_wr_data,
  output logic [DATA_W/8-1:0]   mem_wr_mask,
  output logic [7:0]            wlast_err_cnt
);

  localparam int BYTES   = beat_bytes(DATA_W);
  localparam int OFS     = $clog2(BYTES);
  localparam int WORD_W  = ADDR_W - OFS;
  localparam int AWCNT_W = $clog2(AW_DEPTH) + 1;
  localparam int BCNT_W  = $clog2(B_DEPTH) + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [3:0]        len;
    logic [WORD_W-1:0] word;
  } aw_ent_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_ent_t;

  logic              rst;
  state_t            state_q;
  state_t            state_d;

  aw_ent_t           aw_in;
  aw_ent_t           aw_head;
  logic              aw_push;
  logic              aw_pop;
  logic              aw_full;
  logic              aw_empty;
  logic [AWCNT_W-1:0] aw_count;

  b_ent_t            b_in;
  b_ent_t            b_head;
  logic              b_push;
  logic              b_pop;
  logic              b_full;
  logic              b_empty;
  logic [BCNT_W-1:0] b_count;

  logic [ID_W-1:0]   cur_id;
  logic [3:0]        beat_cnt;
  logic [WORD_W-1:0] cur_addr;
  logic              err;

  logic              w_rdy;
  logic              mem_vld;
  logic              beat;
  logic [1:0]        final_resp;
  logic              unused_bits;

  assign rst = nvdla_core_rst;

  assign mcif2noc_axi_aw_awready = !rst && !aw_full;
  assign aw_push = mcif2noc_axi_aw_awvalid && mcif2noc_axi_aw_awready;
  assign aw_in   = '{id:   mcif2noc_axi_aw_awid,
                     len:  mcif2noc_axi_aw_awlen,
                     word: mcif2noc_axi_aw_awaddr[ADDR_W-1:OFS]};

  mcif_axi_sync_fifo #(
    .WIDTH ($bits(aw_ent_t)),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk      (nvdla_core_clk),
    .rst      (rst),
    .push     (aw_push),
    .push_dat (aw_in),
    .pop      (aw_pop),
    .pop_dat  (aw_head),
    .full     (aw_full),
    .empty    (aw_empty),
    .count    (aw_count)
  );

  // A missing wlast on the final beat and any early wlast both report SLVERR.
  assign final_resp = (mcif2noc_axi_w_wlast && !err) ? RESP_OKAY : RESP_SLVERR;
  assign b_in       = '{id: cur_id, resp: final_resp};

  always_comb begin
    state_d = state_q;
    aw_pop  = 1'b0;
    b_push  = 1'b0;
    w_rdy   = 1'b0;
    mem_vld = 1'b0;
    beat    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only start a burst once its B slot is guaranteed.
        if (!aw_empty && (b_count < BCNT_W'(B_DEPTH))) begin
          aw_pop  = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        w_rdy   = mem_wr_ready;
        mem_vld = mcif2noc_axi_w_wvalid;
        beat    = mcif2noc_axi_w_wvalid && mem_wr_ready;
        if (beat && (beat_cnt == 4'd0)) begin
          b_push  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (rst) begin
      cur_id        <= '0;
      beat_cnt      <= '0;
      cur_addr      <= '0;
      err           <= 1'b0;
      wlast_err_cnt <= '0;
    end else begin
      if (aw_pop) begin
        cur_id   <= aw_head.id;
        beat_cnt <= aw_head.len;
        cur_addr <= aw_head.word;
        err      <= 1'b0;
      end else if (beat) begin
        cur_addr <= cur_addr + WORD_W'(1);
        beat_cnt <= beat_cnt - 4'd1;
        if (mcif2noc_axi_w_wlast && (beat_cnt != 4'd0)) err <= 1'b1;
      end
      if (b_push && (final_resp == RESP_SLVERR) && (wlast_err_cnt != 8'hFF))
        wlast_err_cnt <= wlast_err_cnt + 8'd1;
    end
  end

  assign mcif2noc_axi_w_wready = !rst && w_rdy;
  assign mem_wr_valid          = !rst && mem_vld;
  assign mem_wr_addr           = {cur_addr, {OFS{1'b0}}};
  assign mem_wr_data           = mcif2noc_axi_w_wdata;
  assign mem_wr_mask           = mcif2noc_axi_w_wstrb[BYTES-1:0];

  mcif_axi_sync_fifo #(
    .WIDTH ($bits(b_ent_t)),
    .DEPTH (B_DEPTH)
  ) u_b_fifo (
    .clk      (nvdla_core_clk),
    .rst      (rst),
    .push     (b_push),
    .push_dat (b_in),
    .pop      (b_pop),
    .pop_dat  (b_head),
    .full     (b_full),
    .empty    (b_empty),
    .count    (b_count)
  );

  assign noc2mcif_axi_b_bvalid = !rst && !b_empty;
  assign b_pop                 = noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready;
  assign noc2mcif_axi_b_bid    = noc2mcif_axi_b_bvalid ? b_head.id   : '0;
  assign noc2mcif_axi_b_bresp  = noc2mcif_axi_b_bvalid ? b_head.resp : 2'b00;

  assign unused_bits = ^{mcif2noc_axi_w_wstrb[63:BYTES], mcif2noc_axi_aw_awaddr[OFS-1:0],
                         aw_count, b_full};

endmodule

// File: tb/tb_mcif_axi_wr_responder.sv
// Directed bench for mcif_axi_wr_responder: vector table of bursts plus
// hand-written sequences for AW/B backpressure, memory stalls, reset and saturation.
module tb_mcif_axi_wr_responder;

  logic        clk;
  logic        rst;
  logic        awvalid;
  logic        awready;
  logic [7:0]  awid;
  logic [3:0]  awlen;
  logic [63:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [63:0] wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_mask;
  logic [7:0]  wlast_err_cnt;

  int total;
  int bad;
  int wr_cnt;

  mcif_axi_wr_responder dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rst          (rst),
    .mcif2noc_axi_aw_awvalid (awvalid),
    .mcif2noc_axi_aw_awready (awready),
    .mcif2noc_axi_aw_awid    (awid),
    .mcif2noc_axi_aw_awlen   (awlen),
    .mcif2noc_axi_aw_awaddr  (awaddr),
    .mcif2noc_axi_w_wvalid   (wvalid),
    .mcif2noc_axi_w_wready   (wready),
    .mcif2noc_axi_w_wdata    (wdata),
    .mcif2noc_axi_w_wstrb    (wstrb),
    .mcif2noc_axi_w_wlast    (wlast),
    .noc2mcif_axi_b_bvalid   (bvalid),
    .noc2mcif_axi_b_bready   (bready),
    .noc2mcif_axi_b_bid      (bid),
    .noc2mcif_axi_b_bresp    (bresp),
    .mem_wr_valid            (mem_wr_valid),
    .mem_wr_ready            (mem_wr_ready),
    .mem_wr_addr             (mem_wr_addr),
    .mem_wr_data             (mem_wr_data),
    .mem_wr_mask             (mem_wr_mask),
    .wlast_err_cnt           (wlast_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_wr_valid === 1'b1 && mem_wr_ready === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  len;
    logic [63:0] addr;
    logic [4:0]  early;   // beat index carrying an early wlast, 5'h1F = none
    logic        nolast;  // drop wlast entirely
    logic [1:0]  resp;
    logic [7:0]  cnt;     // expected wlast_err_cnt after the burst
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] strb_of(input int i);
    return 8'((i * 37) + 91);
  endfunction

  task automatic send_aw(input logic [7:0] id, input logic [3:0] len, input logic [63:0] addr);
    int n;
    awvalid = 1'b1;
    awid    = id;
    awlen   = len;
    awaddr  = addr;
    #1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (awready !== 1'b1) begin
      chk("aw_timeout", 64'(awready), 64'd1);
      awvalid = 1'b0;
      return;
    end
    tick();
    awvalid = 1'b0;
  endtask

  // Drives len+1 beats, checks the memory port per beat and the B the cycle after the last one.
  task automatic do_w(input logic [7:0] id, input int len, input logic [63:0] base,
                      input int early, input bit nolast, input logic [1:0] exp_resp,
                      input logic [7:0] exp_bid, input int exp_wait);
    int n;
    logic [63:0] a0;
    a0 = base & ~64'h7;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1;
      wdata  = {8'hA5, id, 40'h0, 8'(i)};
      wstrb  = {56'hFF_FFFF_FFFF_FFFF, strb_of(i)};
      wlast  = nolast ? 1'b0 : ((i == len) || (i == early));
      #1;
      n = 0;
      while (wready !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      if (wready !== 1'b1) begin
        chk("w_timeout", 64'(wready), 64'd1);
        wvalid = 1'b0;
        return;
      end
      if (i == 0 && exp_wait >= 0) chk("first_beat_lat", 64'(n), 64'(exp_wait));
      chk("mem_vld", 64'(mem_wr_valid), 64'd1);
      chk("mem_addr", mem_wr_addr, a0 + 64'(i * 8));
      chk("mem_mask", 64'(mem_wr_mask), 64'(strb_of(i)));
      chk("mem_data", mem_wr_data, {8'hA5, id, 40'h0, 8'(i)});
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("b_vld", 64'(bvalid), 64'd1);
    chk("b_id", 64'(bid), 64'(exp_bid));
    chk("b_resp", 64'(bresp), 64'(exp_resp));
  endtask

  initial begin
    int beat;
    int wr0;
    total        = 0;
    bad          = 0;
    wr_cnt       = 0;
    rst          = 1'b1;
    awvalid      = 1'b0;
    awid         = '0;
    awlen        = '0;
    awaddr       = '0;
    wvalid       = 1'b0;
    wdata        = '0;
    wstrb        = '0;
    wlast        = 1'b0;
    bready       = 1'b1;
    mem_wr_ready = 1'b1;

    vecs[0] = '{8'h03, 4'd3,  64'h1000,                5'h1F, 1'b0, 2'b00, 8'd0};
    vecs[1] = '{8'h5A, 4'd0,  64'h2007,                5'h1F, 1'b0, 2'b00, 8'd0};
    vecs[2] = '{8'h11, 4'd3,  64'h3000,                5'd1,  1'b0, 2'b10, 8'd1};
    vecs[3] = '{8'h22, 4'd1,  64'h4000,                5'h1F, 1'b1, 2'b10, 8'd2};
    vecs[4] = '{8'hFF, 4'd15, 64'h5008,                5'h1F, 1'b0, 2'b00, 8'd2};
    vecs[5] = '{8'h01, 4'd2,  64'hFFFF_FFFF_FFFF_FFF8, 5'h1F, 1'b0, 2'b00, 8'd2};

    tick();
    tick();
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_memvld", 64'(mem_wr_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_bvalid", 64'(bvalid), 64'd0);
    chk("post_rst_bid", 64'(bid), 64'd0);
    chk("post_rst_bresp", 64'(bresp), 64'd0);
    chk("post_rst_errcnt", 64'(wlast_err_cnt), 64'd0);
    tick();

    for (int v = 0; v < 6; v++) begin
      send_aw(vecs[v].id, vecs[v].len, vecs[v].addr);
      do_w(vecs[v].id, int'(vecs[v].len), vecs[v].addr,
           (vecs[v].early == 5'h1F) ? -1 : int'(vecs[v].early),
           vecs[v].nolast, vecs[v].resp, vecs[v].id, 1);
      chk("vec_errcnt", 64'(wlast_err_cnt), 64'(vecs[v].cnt));
    end

    // AW backpressure: burst 0x40 moves straight into DATA, so the FIFO fills with 0x41..0x44.
    for (int k = 0; k < 5; k++) begin
      awvalid = 1'b1;
      awid    = 8'h40 + 8'(k);
      awlen   = 4'd0;
      awaddr  = 64'h9000 + 64'(k * 8);
      #1;
      chk("aw_bb_rdy", 64'(awready), 64'd1);
      tick();
    end
    awid   = 8'h45;
    awaddr = 64'h9028;
    #1;
    chk("aw_full_rdy", 64'(awready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("aw_full_hold", 64'(awready), 64'd0);
    end
    awvalid = 1'b0;
    do_w(8'h40, 0, 64'h9000, -1, 1'b0, 2'b00, 8'h40, -1);
    chk("aw_still_full", 64'(awready), 64'd0);
    tick();
    chk("aw_reopen", 64'(awready), 64'd1);
    send_aw(8'h45, 4'd0, 64'h9028);
    for (int k = 1; k < 6; k++)
      do_w(8'h40 + 8'(k), 0, 64'h9000 + 64'(k * 8), -1, 1'b0, 2'b00, 8'h40 + 8'(k), -1);

    // B backpressure: four B held, fifth burst must wait in IDLE.
    tick();
    bready = 1'b0;
    for (int k = 0; k < 5; k++) send_aw(8'h50 + 8'(k), 4'd0, 64'hA000 + 64'(k * 64));
    for (int k = 0; k < 4; k++)
      do_w(8'h50 + 8'(k), 0, 64'hA000 + 64'(k * 64), -1, 1'b0, 2'b00, 8'h50, -1);
    wvalid = 1'b1;
    wdata  = {8'hA5, 8'h54, 48'h0};
    wstrb  = 64'hFF;
    wlast  = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bfull_wready", 64'(wready), 64'd0);
      chk("bfull_bid", 64'(bid), 64'h50);
      tick();
    end
    bready = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("bdrain_vld", 64'(bvalid), (c < 5) ? 64'd1 : 64'd0);
      if (c < 5) chk("bdrain_id", 64'(bid), 64'h50 + 64'(c));
      if (c == 4) chk("bdrain_resp", 64'(bresp), 64'd0);
      chk("bdrain_wready", 64'(wready), (c == 2) ? 64'd1 : 64'd0);
      if (c == 2) chk("bdrain_addr", mem_wr_addr, 64'hA100);
      tick();
      if (c == 2) begin
        wvalid = 1'b0;
        wlast  = 1'b0;
      end
    end

    // Memory stalls every other cycle over a 16-beat... here 8-beat burst.
    send_aw(8'h66, 4'd7, 64'hB000);
    wvalid = 1'b1;
    tick();
    beat = 0;
    wr0  = wr_cnt;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      mem_wr_ready = (c % 2 == 0);
      wdata = {8'h66, 48'h0, 8'(beat)};
      wstrb = {56'h0, strb_of(beat)};
      wlast = (beat == 7);
      #1;
      chk("tog_wready", 64'(wready), (c % 2 == 0) ? 64'd1 : 64'd0);
      chk("tog_memvld", 64'(mem_wr_valid), 64'd1);
      if (c % 2 == 0) begin
        chk("tog_mask", 64'(mem_wr_mask), 64'(strb_of(beat)));
        chk("tog_addr", mem_wr_addr, 64'hB000 + 64'(beat * 8));
        beat++;
      end
      tick();
    end
    wvalid       = 1'b0;
    wlast        = 1'b0;
    mem_wr_ready = 1'b1;
    chk("tog_bvld", 64'(bvalid), 64'd1);
    chk("tog_bid", 64'(bid), 64'h66);
    chk("tog_bresp", 64'(bresp), 64'd0);
    tick();
    tick();
    chk("tog_wr_cnt", 64'(wr_cnt - wr0), 64'd8);

    // Reset in the middle of a burst with another AW queued behind it.
    send_aw(8'h77, 4'd3, 64'h8000);
    send_aw(8'h78, 4'd0, 64'h8800);
    wvalid = 1'b1;
    wlast  = 1'b0;
    wstrb  = 64'hFF;
    for (int i = 0; i < 2; i++) begin
      wdata = 64'(i);
      #1;
      beat = 0;
      while (wready !== 1'b1 && beat < 20) begin
        tick();
        beat++;
      end
      chk("pre_rst_beat", 64'(wready), 64'd1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_wready", 64'(wready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_bvalid", 64'(bvalid), 64'd0);
    chk("after_rst_wready", 64'(wready), 64'd0);
    chk("after_rst_memvld", 64'(mem_wr_valid), 64'd0);
    chk("after_rst_errcnt", 64'(wlast_err_cnt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("after_rst_idle_w", 64'(wready), 64'd0);
      chk("after_rst_idle_b", 64'(bvalid), 64'd0);
    end
    wvalid = 1'b0;
    send_aw(8'h79, 4'd1, 64'hC000);
    do_w(8'h79, 1, 64'hC000, -1, 1'b0, 2'b00, 8'h79, 1);
    chk("fresh_errcnt", 64'(wlast_err_cnt), 64'd0);

    // Error counter saturation: 256 single-beat bursts without wlast.
    for (int i = 0; i < 256; i++) begin
      send_aw(8'(i), 4'd0, 64'hD000);
      do_w(8'(i), 0, 64'hD000, -1, 1'b1, 2'b10, 8'(i), -1);
      chk("sat_errcnt", 64'(wlast_err_cnt), (i + 1 > 255) ? 64'd255 : 64'(i + 1));
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
